// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Summary  : Multicycle processor control FSM. The outputs depend on the state
//            only, except that the FETCH strobes are gated by MemReady.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [3:0] ALUOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ANDIEX = 4'd10, ORIEX  = 4'd11,
        IMMWB  = 4'd12, JUMP   = 4'd13
    } state_t;

    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_j     = 6'b000010;

    state_t r_state;
    state_t w_next;
    state_t w_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // During reset the outputs show FETCH, with its write strobes suppressed
        w_cur       = rst ? FETCH : r_state;
        w_next      = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        ALUOp       = 4'b0000;
        case (w_cur)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = MemReady & ~rst;
                IRWrite = MemReady & ~rst;
                w_next  = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    c_op_lw, c_op_sw: w_next = MEMADR;
                    c_op_rtype:       w_next = EXEC;
                    c_op_beq:         w_next = BRANCH;
                    c_op_addi:        w_next = ADDIEX;
                    c_op_andi:        w_next = ANDIEX;
                    c_op_ori:         w_next = ORIEX;
                    c_op_j:           w_next = JUMP;
                    default:          w_next = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (Op == c_op_lw) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                w_next  = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                w_next   = MemReady ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 4'b0010;
                w_next  = RWB;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 4'b0001;
                PCWriteCond = 1'b1;
                PCSrc       = 2'b01;
            end
            ADDIEX, ANDIEX, ORIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (w_cur == ANDIEX) ? 4'b0011 :
                          (w_cur == ORIEX)  ? 4'b0100 : 4'b0000;
                w_next  = IMMWB;
            end
            IMMWB: begin
                RegWrite = 1'b1;
            end
            JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    assign State = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Summary  : Self-checking bench for multicycle_control against a model built
//            from per-instruction state sequences and a per-state output table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUOp, State;
    logic [17:0] ctrl;

    int checks = 0;
    int passed = 0;
    int q[$];
    logic [5:0] cur_op;
    logic [5:0] ops[8] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000,
                           6'b001100, 6'b001101, 6'b000100, 6'b000010};
    int cyc_exp[8] = '{5, 4, 4, 4, 4, 4, 3, 3};

    multicycle_control dut (
        .clk(clk), .rst(rst), .Op(Op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .ALUOp(ALUOp), .State(State)
    );

    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for a state, straight from the per-state output list
    function automatic logic [17:0] exp_ctrl(input int s, input logic mr, input logic in_rst);
        logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa;
        logic [1:0] asb, pcs;
        logic [3:0] aop;
        {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa} = '0;
        asb = 2'd0; pcs = 2'd0; aop = 4'd0;
        case (s)
            0:  begin mrd = 1; asb = 2'd1; pcw = mr & ~in_rst; irw = mr & ~in_rst; end
            1:  asb = 2'd3;
            2:  begin asa = 1; asb = 2'd2; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 4'd2; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 4'd1; pcwc = 1; pcs = 2'd1; end
            9:  begin asa = 1; asb = 2'd2; end
            10: begin asa = 1; asb = 2'd2; aop = 4'd3; end
            11: begin asa = 1; asb = 2'd2; aop = 4'd4; end
            12: rw = 1;
            13: begin pcw = 1; pcs = 2'd2; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, pcs, aop};
    endfunction

    // State sequence visited by one instruction, starting at FETCH
    task automatic load(input logic [5:0] op);
        case (op)
            6'b100011: q = '{0, 1, 2, 3, 4};
            6'b101011: q = '{0, 1, 2, 5};
            6'b000000: q = '{0, 1, 6, 7};
            6'b000100: q = '{0, 1, 8};
            6'b001000: q = '{0, 1, 9, 12};
            6'b001100: q = '{0, 1, 10, 12};
            6'b001101: q = '{0, 1, 11, 12};
            6'b000010: q = '{0, 1, 13};
            default:   q = '{0, 1};
        endcase
    endtask

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        int n;
        int k;
        logic mr;
        logic rw_seen;

        rst = 1'b1; MemReady = 1'b1; Op = 6'b100011;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {14'd0, State}, 18'd0);
        chk("reset_ctrl", ctrl, exp_ctrl(0, 1'b1, 1'b1));
        rst = 1'b0;

        // Instruction latency with memory always ready
        for (int i = 0; i < 9; i++) begin
            Op = (i < 8) ? ops[i] : 6'b111111;
            MemReady = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (State !== 4'd0 && n < 20);
            chk($sformatf("cycles_op%b", Op), 18'(n), 18'((i < 8) ? cyc_exp[i] : 2));
        end
        MemReady = 1'b0;

        // Random instruction stream with random memory stalls
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                k = $urandom_range(0, 8);
                cur_op = (k < 8) ? ops[k] : 6'($urandom);
                load(cur_op);
            end
            mr = ($urandom_range(0, 3) != 0);
            MemReady = mr;
            Op = (q[0] == 1 || q[0] == 2) ? cur_op : 6'($urandom);
            #1;
            chk($sformatf("rand_state_c%0d", c), {14'd0, State}, 18'(q[0]));
            chk($sformatf("rand_ctrl_c%0d_s%0d", c, q[0]), ctrl, exp_ctrl(q[0], mr, 1'b0));
            if (!((q[0] == 0 || q[0] == 3 || q[0] == 5) && !mr)) void'(q.pop_front());
        end

        // Reset taken while a load is stalled in MEMRD
        @(negedge clk);
        rst = 1'b1; MemReady = 1'b1;
        @(negedge clk);
        rst = 1'b0; Op = 6'b100011;
        rw_seen = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1 rw_seen |= RegWrite;
        end
        MemReady = 1'b0;
        @(posedge clk);
        #1 rw_seen |= RegWrite;
        chk("memrd_hold_state", {14'd0, State}, 18'd3);
        rst = 1'b1;
        #1 chk("rst_ctrl_in_memrd", ctrl, exp_ctrl(0, 1'b0, 1'b1));
        @(posedge clk);
        #1 rw_seen |= RegWrite;
        chk("memrd_rst_state", {14'd0, State}, 18'd0);
        chk("memrd_no_regwrite", {17'd0, rw_seen}, 18'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
